// File: rtl/rpn_lan_to_network_bridge_merger.sv
// Packet-locked 3:1 AXIS merger (seq-num init, LAN TX, LAN RX) feeding the network bridge through a skid-buffered output stage.
// Build option: RPN_LAN_MERGER_STRICT_PRIORITY_EN selects fixed priority (source 0 > 1 > 2) instead of round-robin.
module rpn_lan_to_network_bridge_merger #(
  parameter int AXIS_DATA_WIDTH        = 32,
  parameter int AXIS_KEEP_WIDTH        = AXIS_DATA_WIDTH/8,
  parameter int AXIS_TO_NB_TDEST_WIDTH = 8,
  parameter int AXIS_TO_NB_TUSER_WIDTH = 32
) (
  input  logic                              i_clk,
  input  logic                              i_ap_rst_n,

  input  logic                              from_rpn_LAN_seq_num_initializer_tvalid,
  output logic                              from_rpn_LAN_seq_num_initializer_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        from_rpn_LAN_seq_num_initializer_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]        from_rpn_LAN_seq_num_initializer_tkeep,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_seq_num_initializer_tid,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_seq_num_initializer_tdest,
  input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rpn_LAN_seq_num_initializer_tuser,
  input  logic                              from_rpn_LAN_seq_num_initializer_tlast,

  input  logic                              from_rpn_LAN_TX_tvalid,
  output logic                              from_rpn_LAN_TX_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        from_rpn_LAN_TX_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]        from_rpn_LAN_TX_tkeep,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_TX_tid,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_TX_tdest,
  input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rpn_LAN_TX_tuser,
  input  logic                              from_rpn_LAN_TX_tlast,

  input  logic                              from_rpn_LAN_RX_tvalid,
  output logic                              from_rpn_LAN_RX_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]        from_rpn_LAN_RX_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]        from_rpn_LAN_RX_tkeep,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_RX_tid,
  input  logic [AXIS_TO_NB_TDEST_WIDTH-1:0] from_rpn_LAN_RX_tdest,
  input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0] from_rpn_LAN_RX_tuser,
  input  logic                              from_rpn_LAN_RX_tlast,

  output logic                              to_network_bridge_tvalid,
  input  logic                              to_network_bridge_tready,
  output logic [AXIS_DATA_WIDTH-1:0]        to_network_bridge_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]        to_network_bridge_tkeep,
  output logic [AXIS_TO_NB_TDEST_WIDTH-1:0] to_network_bridge_tid,
  output logic [AXIS_TO_NB_TDEST_WIDTH-1:0] to_network_bridge_tdest,
  output logic [AXIS_TO_NB_TUSER_WIDTH-1:0] to_network_bridge_tuser,
  output logic                              to_network_bridge_tlast,

  output logic [1:0]                        o_grant
);

  localparam int BEAT_W = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 2*AXIS_TO_NB_TDEST_WIDTH
                        + AXIS_TO_NB_TUSER_WIDTH + 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t            state, state_next;
  logic [1:0]        lock_src, lock_src_next;
  logic [1:0]        pick, sel;
  logic [2:0]        src_valid;
  logic [BEAT_W-1:0] src_beat [3];
  logic [BEAT_W-1:0] in_beat, main_beat, skid_beat;
  logic              any_valid, sel_valid, in_ready, accept, in_last, grant_en;
  logic              main_valid, skid_valid;

  // Beats are carried as one flat word with tlast in bit 0.
  assign src_valid = {from_rpn_LAN_RX_tvalid, from_rpn_LAN_TX_tvalid,
                      from_rpn_LAN_seq_num_initializer_tvalid};
  assign src_beat[0] = {from_rpn_LAN_seq_num_initializer_tdata, from_rpn_LAN_seq_num_initializer_tkeep,
                        from_rpn_LAN_seq_num_initializer_tid, from_rpn_LAN_seq_num_initializer_tdest,
                        from_rpn_LAN_seq_num_initializer_tuser, from_rpn_LAN_seq_num_initializer_tlast};
  assign src_beat[1] = {from_rpn_LAN_TX_tdata, from_rpn_LAN_TX_tkeep, from_rpn_LAN_TX_tid,
                        from_rpn_LAN_TX_tdest, from_rpn_LAN_TX_tuser, from_rpn_LAN_TX_tlast};
  assign src_beat[2] = {from_rpn_LAN_RX_tdata, from_rpn_LAN_RX_tkeep, from_rpn_LAN_RX_tid,
                        from_rpn_LAN_RX_tdest, from_rpn_LAN_RX_tuser, from_rpn_LAN_RX_tlast};

`ifdef RPN_LAN_MERGER_STRICT_PRIORITY_EN
  always_comb begin
    if (src_valid[0])      pick = 2'd0;
    else if (src_valid[1]) pick = 2'd1;
    else                   pick = 2'd2;
  end
`else
  logic [1:0] last_grant;
  logic [1:0] rr_cand;
  logic       rr_found;

  always_comb begin
    pick     = 2'd0;
    rr_cand  = 2'd0;
    rr_found = 1'b0;
    for (int unsigned k = 1; k <= 3; k++) begin
      rr_cand = 2'((32'(last_grant) + k) % 3);
      if (!rr_found && src_valid[rr_cand]) begin
        pick     = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n)          last_grant <= 2'd2;
    else if (accept && in_last) last_grant <= sel;
  end
`endif

  // Reset gates ready combinationally so sources see tready low as soon as reset asserts.
  always_comb begin
    any_valid = |src_valid;
    sel       = (state == ST_LOCKED) ? lock_src : pick;
    sel_valid = (state == ST_LOCKED) ? src_valid[sel] : any_valid;
    in_ready  = i_ap_rst_n & ~skid_valid;
    accept    = sel_valid & in_ready;
    in_beat   = src_beat[sel];
    in_last   = in_beat[0];
    grant_en  = in_ready & ((state == ST_LOCKED) | any_valid);
    from_rpn_LAN_seq_num_initializer_tready = grant_en & (sel == 2'd0);
    from_rpn_LAN_TX_tready                  = grant_en & (sel == 2'd1);
    from_rpn_LAN_RX_tready                  = grant_en & (sel == 2'd2);
  end

  always_comb begin
    state_next    = state;
    lock_src_next = lock_src;
    if (accept) begin
      if (in_last) begin
        state_next = ST_IDLE;
      end else begin
        state_next    = ST_LOCKED;
        lock_src_next = sel;
      end
    end
    o_grant = (state == ST_LOCKED) ? lock_src : 2'd3;
  end

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state    <= ST_IDLE;
      lock_src <= 2'd0;
    end else begin
      state    <= state_next;
      lock_src <= lock_src_next;
    end
  end

  // Skid register only catches a beat accepted while the main register is stalled.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_beat  <= '0;
      skid_beat  <= '0;
    end else if (accept) begin
      if (main_valid && !to_network_bridge_tready) begin
        skid_valid <= 1'b1;
        skid_beat  <= in_beat;
      end else begin
        main_valid <= 1'b1;
        main_beat  <= in_beat;
      end
    end else if (to_network_bridge_tready || !main_valid) begin
      if (skid_valid) begin
        main_beat  <= skid_beat;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= 1'b0;
      end
    end
  end

  assign to_network_bridge_tvalid = main_valid;
  assign {to_network_bridge_tdata, to_network_bridge_tkeep, to_network_bridge_tid,
          to_network_bridge_tdest, to_network_bridge_tuser, to_network_bridge_tlast} = main_beat;

endmodule
